// File: rtl/csa_resolve_err.sv
// csa_resolve_err
// Turns the redundant sum/carry vectors from the filter's compression tree into a
// binary output y. The carry-propagate add is split into two pipelined halves.
// The stage then forms the saturated error e = d - y and the LMS step e >>> MU_SHIFT.
// Three registered stages share one advance enable, so a stalled consumer freezes
// the whole pipe. A saturating counter records how many delivered samples were clipped.
module csa_resolve_err #(
    parameter int W_CS     = 11,
    parameter int W_OUT    = 12,
    parameter int SPLIT    = 6,
    parameter int MU_SHIFT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_CS-1:0]      s_in,
    input  logic [W_CS-1:0]      c_in,
    input  logic [W_OUT-1:0]     d_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_OUT-1:0]     y,
    output logic [W_OUT-1:0]     e,
    output logic [W_OUT-1:0]     step,
    output logic                 sat,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     sat_cnt
);

    // y keeps only the low W_OUT bits of the resolved sum, so the upper half of the
    // adder is W_OUT-SPLIT bits wide. The extra sign bit of a W_OUT+1 add could never
    // reach y, so it is not built.
    localparam int W_HI  = W_OUT - SPLIT;
    localparam int W_EXT = W_OUT + 1;

    // Sign-extend a carry-save operand to the output width.
    function automatic logic [W_OUT-1:0] sext_cs(input logic [W_CS-1:0] v);
        return {{(W_OUT-W_CS){v[W_CS-1]}}, v};
    endfunction

    // Clip a W_OUT+1 bit difference into W_OUT bits; MSB of the result flags a clip.
    function automatic logic [W_OUT:0] clip_diff(input logic [W_EXT-1:0] diff);
        logic [W_OUT:0] res;
        if (diff[W_EXT-1] != diff[W_EXT-2]) begin
            if (diff[W_EXT-1]) begin
                res = {1'b1, 1'b1, {(W_OUT-1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(W_OUT-1){1'b1}}};
            end
        end else begin
            res = {1'b0, diff[W_OUT-1:0]};
        end
        return res;
    endfunction

    logic                 w_adv;
    logic [W_OUT-1:0]     w_s_ext;
    logic [W_OUT-1:0]     w_c_ext;
    logic [SPLIT:0]       w_lo_sum;
    logic [W_HI-1:0]      w_hi_sum;
    logic [W_EXT-1:0]     w_diff;
    logic [W_OUT:0]       w_clip;
    logic [W_OUT-1:0]     w_step;
    logic                 w_hs;

    logic                 r_s1_v;
    logic [SPLIT-1:0]     r_s1_lo;
    logic                 r_s1_cy;
    logic [W_HI-1:0]      r_s1_s_hi;
    logic [W_HI-1:0]      r_s1_c_hi;
    logic [W_OUT-1:0]     r_s1_d;

    logic                 r_s2_v;
    logic [W_OUT-1:0]     r_s2_y;
    logic [W_OUT-1:0]     r_s2_d;

    logic                 r_s3_v;
    logic [W_OUT-1:0]     r_y;
    logic [W_OUT-1:0]     r_e;
    logic [W_OUT-1:0]     r_step;
    logic                 r_sat;
    logic [CNT_W-1:0]     r_cnt;

    assign w_adv    = !r_s3_v || out_ready;
    assign in_ready = w_adv;
    assign w_hs     = r_s3_v && out_ready;

    // Stage datapaths: low-half add, upper-half add with carry, error, clip and step.
    always_comb begin
        w_s_ext  = sext_cs(s_in);
        w_c_ext  = sext_cs(c_in);
        w_lo_sum = {1'b0, w_s_ext[SPLIT-1:0]} + {1'b0, w_c_ext[SPLIT-1:0]};
        w_hi_sum = r_s1_s_hi + r_s1_c_hi + {{(W_HI-1){1'b0}}, r_s1_cy};
        w_diff   = {r_s2_d[W_OUT-1], r_s2_d} - {r_s2_y[W_OUT-1], r_s2_y};
        w_clip   = clip_diff(w_diff);
        w_step   = $signed(w_clip[W_OUT-1:0]) >>> MU_SHIFT;
    end

    // Pipeline registers: every stage (data and valid) moves only when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_lo   <= {SPLIT{1'b0}};
            r_s1_cy   <= 1'b0;
            r_s1_s_hi <= {W_HI{1'b0}};
            r_s1_c_hi <= {W_HI{1'b0}};
            r_s1_d    <= {W_OUT{1'b0}};
            r_s2_v    <= 1'b0;
            r_s2_y    <= {W_OUT{1'b0}};
            r_s2_d    <= {W_OUT{1'b0}};
            r_s3_v    <= 1'b0;
            r_y       <= {W_OUT{1'b0}};
            r_e       <= {W_OUT{1'b0}};
            r_step    <= {W_OUT{1'b0}};
            r_sat     <= 1'b0;
        end else if (w_adv) begin
            r_s1_v    <= in_valid;
            r_s1_lo   <= w_lo_sum[SPLIT-1:0];
            r_s1_cy   <= w_lo_sum[SPLIT];
            r_s1_s_hi <= w_s_ext[W_OUT-1:SPLIT];
            r_s1_c_hi <= w_c_ext[W_OUT-1:SPLIT];
            r_s1_d    <= d_in;
            r_s2_v    <= r_s1_v;
            r_s2_y    <= {w_hi_sum, r_s1_lo};
            r_s2_d    <= r_s1_d;
            r_s3_v    <= r_s2_v;
            r_y       <= r_s2_y;
            r_e       <= w_clip[W_OUT-1:0];
            r_step    <= w_step;
            r_sat     <= w_clip[W_OUT];
        end else begin
            r_s1_v    <= r_s1_v;
            r_s2_v    <= r_s2_v;
            r_s3_v    <= r_s3_v;
        end
    end

    // Clip event counter: clear wins, otherwise count clipped handshakes and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_hs && r_sat && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign out_valid = r_s3_v;
    assign y         = r_y;
    assign e         = r_e;
    assign step      = r_step;
    assign sat       = r_sat;
    assign sat_cnt   = r_cnt;

endmodule

// File: tb/tb_csa_resolve_err.sv
// Self-checking bench for csa_resolve_err: a reference model fills a scoreboard queue
// whenever a sample is accepted; each output handshake pops and compares it.
module tb_csa_resolve_err;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] s_in;
    logic [10:0] c_in;
    logic [11:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] y;
    logic [11:0] e;
    logic [11:0] step;
    logic        sat;
    logic        clr_cnt;
    logic [15:0] sat_cnt;

    typedef struct packed {
        logic [11:0] y;
        logic [11:0] e;
        logic [11:0] step;
        logic        sat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic [15:0] exp_cnt = 16'd0;
    exp_t        last_out;

    csa_resolve_err dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .e         (e),
        .step      (step),
        .sat       (sat),
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width sum, error, clip to 12 bits, arithmetic shift by 3.
    function automatic exp_t model(input logic [10:0] s, input logic [10:0] c, input logic [11:0] d);
        exp_t r;
        logic signed [12:0] ys;
        logic signed [12:0] df;
        ys  = $signed({{2{s[10]}}, s}) + $signed({{2{c[10]}}, c});
        r.y = ys[11:0];
        df  = $signed({d[11], d}) - $signed({r.y[11], r.y});
        if (df > 13'sd2047) begin
            r.e = 12'h7FF; r.sat = 1'b1;
        end else if (df < -13'sd2048) begin
            r.e = 12'h800; r.sat = 1'b1;
        end else begin
            r.e = df[11:0]; r.sat = 1'b0;
        end
        r.step = 12'($signed(r.e) >>> 3);
        return r;
    endfunction

    // One clock: entered at a negedge with inputs set; scores any output handshake,
    // records any accepted input, advances to the next negedge and checks sat_cnt.
    task automatic cycle(output bit acc);
        exp_t ex;
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got y=%h e=%h step=%h sat=%b, expected no output", y, e, step, sat);
            end else begin
                ex = sb.pop_front();
                if ({y, e, step, sat} !== ex) begin
                    errors++;
                    $display("FAIL scoreboard got y=%h e=%h step=%h sat=%b expected y=%h e=%h step=%h sat=%b",
                             y, e, step, sat, ex.y, ex.e, ex.step, ex.sat);
                end
                if (ex.sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            last_out = {y, e, step, sat};
            n_out++;
        end
        if (clr_cnt) exp_cnt = 16'd0;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (acc) sb.push_back(model(s_in, c_in, d_in));
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sat_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sat_cnt got %0d expected %0d", sat_cnt, exp_cnt);
        end
    endtask

    // Send one sample into an empty pipe, then bubble until it is delivered.
    task automatic send_one(input logic [10:0] s, input logic [10:0] c, input logic [11:0] d, output int lat);
        bit acc;
        int n0;
        in_valid = 1'b1; s_in = s; c_in = c; d_in = d; out_ready = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept got in_ready=%b expected 1", in_ready);
        end
        n0  = n_out;
        lat = 0;
        while (n_out == n0 && lat < 10) begin
            lat++;
            cycle(acc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, y, e, step, sat, sat_cnt, in_ready} !== {1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL reset got out_valid=%b y=%h e=%h step=%h sat=%b sat_cnt=%h in_ready=%b expected all 0, in_ready=1",
                     out_valid, y, e, step, sat, sat_cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [10:0] s, input logic [10:0] c,
                                 input logic [11:0] d, input exp_t want, input logic [15:0] want_cnt);
        int lat;
        send_one(s, c, d, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s_latency got %0d expected 3", name, lat);
        end
        checks++;
        if (last_out !== want) begin
            errors++;
            $display("FAIL %s got y=%h e=%h step=%h sat=%b expected y=%h e=%h step=%h sat=%b", name,
                     last_out.y, last_out.e, last_out.step, last_out.sat, want.y, want.e, want.step, want.sat);
        end
        checks++;
        if (sat_cnt !== want_cnt) begin
            errors++;
            $display("FAIL %s_cnt got %0d expected %0d", name, sat_cnt, want_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] sa[8];
        logic [10:0] ca[8];
        logic [11:0] da[8];
        logic [36:0] held;
        bit          have_held;
        bit          acc;
        int          idx;
        int          cyc;
        int          outs0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = 11'($urandom_range(0, 2047));
            ca[i] = 11'($urandom_range(0, 2047));
            da[i] = 12'($urandom_range(0, 4095));
        end
        sa[1] = 11'h3FF; ca[1] = 11'h3FF; da[1] = 12'h800;
        sa[5] = 11'h400; ca[5] = 11'h400; da[5] = 12'h7FF;
        idx = 0; cyc = 0; have_held = 1'b0; held = '0;
        outs0 = n_out;
        while ((idx < 8 || sb.size() > 0) && cyc < 60) begin
            in_valid  = (idx < 8);
            if (idx < 8) begin
                s_in = sa[idx]; c_in = ca[idx]; d_in = da[idx];
            end
            out_ready = !(cyc >= 4 && cyc < 9);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b expected 0", in_ready);
                end
                if (have_held) begin
                    checks++;
                    if ({y, e, step, sat} !== held) begin
                        errors++;
                        $display("FAIL stall_stable got %h expected %h", {y, e, step, sat}, held);
                    end
                end
                held = {y, e, step, sat};
                have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            cycle(acc);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if ((n_out - outs0) != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count got %0d outputs (%0d pending) expected 8 (0 pending)", n_out - outs0, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit acc;
        int lat;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; s_in = 11'h3FF; c_in = 11'h3FF; d_in = 12'h800;
            cycle(acc);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset got out_valid=%b sat_cnt=%0d expected 0 and 0", out_valid, sat_cnt);
        end
        sb.delete();
        exp_cnt = 16'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_one(11'd5, 11'd3, 12'd100, lat);
        checks++;
        if (lat != 3 || last_out.y !== 12'd8) begin
            errors++;
            $display("FAIL post_reset got lat=%0d y=%h expected lat=3 y=008", lat, last_out.y);
        end
        in_valid = 1'b1; s_in = 11'h3FF; c_in = 11'h3FF; d_in = 12'h800;
        cycle(acc);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            cycle(acc);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || sat !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup got out_valid=%b sat=%b expected 1 and 1", out_valid, sat);
        end
        clr_cnt = 1'b1;
        cycle(acc);
        clr_cnt = 1'b0;
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_priority got %0d expected 0", sat_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        s_in = 11'd0; c_in = 11'd0; d_in = 12'd0; last_out = '0;
        test_reset();
        test_directed("basic",     11'd5,   11'd3,   12'd100, {12'd8,   12'd92,  12'd11,  1'b0}, 16'd0);
        test_directed("sign_ext",  11'h7FF, 11'h7FF, 12'd0,   {12'hFFE, 12'd2,   12'd0,   1'b0}, 16'd0);
        test_directed("saturate",  11'h3FF, 11'h3FF, 12'h800, {12'd2046, 12'h800, 12'hF00, 1'b1}, 16'd1);
        test_directed("split_cy",  11'h03F, 11'h001, 12'd0,   {12'd64,  12'hFC0, 12'hFF8, 1'b0}, 16'd1);
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
